prog_loader: RTL and testbench

//  Host-side loader/debug engine for the pipelined core. It accepts a byte stream (valid/ready)
//  and has two commands. LOAD writes 16-bit words into instruction memory while holding the core
//  in reset. DUMP reads the register file via the user read ports and returns the values as bytes.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host byte-stream loader (IM write under core reset) and RF dump engine
module prog_loader #(
    parameter int         ADDR_W   = 8,
    parameter int         RF_AW    = 3,
    parameter logic [7:0] CMD_LOAD = 8'hA5,
    parameter logic [7:0] CMD_DUMP = 8'h5A
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_data,
    output logic              im_wren,
    output logic              core_srst,
    output logic              rf_user,
    output logic [RF_AW-1:0]  rf_addr1,
    output logic [RF_AW-1:0]  rf_addr2,
    input  logic [7:0]        rf_data1,
    input  logic [7:0]        rf_data2,
    output logic              busy,
    output logic              err
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN    = 4'd1;
    localparam logic [3:0] S_LO     = 4'd2;
    localparam logic [3:0] S_HI     = 4'd3;
    localparam logic [3:0] S_WR     = 4'd4;
    localparam logic [3:0] S_D_ADDR = 4'd5;
    localparam logic [3:0] S_D_WAIT = 4'd6;
    localparam logic [3:0] S_D_S1   = 4'd7;
    localparam logic [3:0] S_D_S2   = 4'd8;

    localparam logic [RF_AW-1:0] LAST_A1 = RF_AW'(2**RF_AW - 2);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       im_data_q, im_data_d;
    logic              im_wren_q, im_wren_d;
    logic              core_srst_q, core_srst_d;
    logic              in_ready_q, in_ready_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [7:0]        data2_q, data2_d;
    logic              out_valid_q, out_valid_d;
    logic              rf_user_q, rf_user_d;
    logic [RF_AW-1:0]  rf_addr1_q, rf_addr1_d;
    logic [RF_AW-1:0]  rf_addr2_q, rf_addr2_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              take;

    assign take = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        lo_d        = lo_q;
        im_data_d   = im_data_q;
        im_wren_d   = 1'b0;
        core_srst_d = core_srst_q;
        out_data_d  = out_data_q;
        data2_d     = data2_q;
        out_valid_d = out_valid_q;
        rf_user_d   = rf_user_q;
        rf_addr1_d  = rf_addr1_q;
        rf_addr2_d  = rf_addr2_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (take) begin
                if (in_data == CMD_LOAD) begin
                    state_d     = S_LEN;
                    core_srst_d = 1'b1;
                end else if (in_data == CMD_DUMP) begin
                    state_d    = S_D_ADDR;
                    rf_user_d  = 1'b1;
                    rf_addr1_d = RF_AW'(0);
                    rf_addr2_d = RF_AW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            // A length byte of 0 wraps len-1 to the top address, giving a full 2**ADDR_W load.
            S_LEN: if (take) begin
                len_d   = in_data[ADDR_W-1:0];
                addr_d  = '0;
                state_d = S_LO;
            end
            S_LO: if (take) begin
                lo_d    = in_data;
                state_d = S_HI;
            end
            S_HI: if (take) begin
                im_data_d = {in_data, lo_q};
                im_wren_d = 1'b1;
                state_d   = S_WR;
            end
            S_WR: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == len_q - ADDR_W'(1)) begin
                    state_d     = S_IDLE;
                    core_srst_d = 1'b0;
                end else begin
                    state_d = S_LO;
                end
            end
            S_D_ADDR: state_d = S_D_WAIT;
            S_D_WAIT: begin
                out_data_d  = rf_data1;
                data2_d     = rf_data2;
                out_valid_d = 1'b1;
                state_d     = S_D_S1;
            end
            S_D_S1: if (out_ready) begin
                out_data_d = data2_q;
                state_d    = S_D_S2;
            end
            S_D_S2: if (out_ready) begin
                out_valid_d = 1'b0;
                if (rf_addr1_q == LAST_A1) begin
                    rf_user_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    rf_addr1_d = rf_addr1_q + RF_AW'(2);
                    rf_addr2_d = rf_addr2_q + RF_AW'(2);
                    state_d    = S_D_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LEN) ||
                     (state_d == S_LO)   || (state_d == S_HI);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            lo_q        <= '0;
            im_data_q   <= '0;
            im_wren_q   <= 1'b0;
            core_srst_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            data2_q     <= '0;
            out_valid_q <= 1'b0;
            rf_user_q   <= 1'b0;
            rf_addr1_q  <= '0;
            rf_addr2_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            lo_q        <= lo_d;
            im_data_q   <= im_data_d;
            im_wren_q   <= im_wren_d;
            core_srst_q <= core_srst_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            data2_q     <= data2_d;
            out_valid_q <= out_valid_d;
            rf_user_q   <= rf_user_d;
            rf_addr1_q  <= rf_addr1_d;
            rf_addr2_q  <= rf_addr2_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign im_addr   = addr_q;
    assign im_data   = im_data_q;
    assign im_wren   = im_wren_q;
    assign core_srst = core_srst_q;
    assign rf_user   = rf_user_q;
    assign rf_addr1  = rf_addr1_q;
    assign rf_addr2  = rf_addr2_q;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a queue-based model
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  im_addr;
    logic [15:0] im_data;
    logic        im_wren;
    logic        core_srst;
    logic        rf_user;
    logic [2:0]  rf_addr1;
    logic [2:0]  rf_addr2;
    logic [7:0]  rf_data1;
    logic [7:0]  rf_data2;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .srst(srst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .im_addr(im_addr), .im_data(im_data), .im_wren(im_wren),
        .core_srst(core_srst), .rf_user(rf_user),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .busy(busy), .err(err)
    );

    logic [7:0] rf [8];
    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [23:0] got_wr[$];
    logic [23:0] exp_wr[$];
    logic [15:0] ld_w[$];
    int          srst_viol = 0;
    bit          bp = 0;

    always @(negedge clk) begin
        if (im_wren) begin
            got_wr.push_back({im_addr, im_data});
            if (!core_srst) srst_viol++;
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        if (bp) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check_eq({tag, "_word"}, got_wr[i], exp_wr[i]);
    endtask

    task automatic do_load(input logic [7:0] nfield);
        int nw;
        nw = (nfield == 0) ? 256 : int'(nfield);
        got_wr.delete();
        exp_wr.delete();
        for (int i = 0; i < nw; i++) exp_wr.push_back({8'(i), ld_w[i]});
        send(8'hA5);
        check_eq("load_core_srst_on", core_srst, 1'b1);
        send(nfield);
        for (int i = 0; i < nw; i++) begin
            send(ld_w[i][7:0]);
            send(ld_w[i][15:8]);
        end
        check_eq("last_wr_pulse", im_wren, 1'b1);
        check_eq("last_wr_core_srst", core_srst, 1'b1);
        @(negedge clk);
        check_eq("post_load_core_srst", core_srst, 1'b0);
        check_eq("post_load_busy", busy, 1'b0);
        check_eq("post_load_in_ready", in_ready, 1'b1);
        check_eq("post_load_addr", im_addr, 8'(nw));
        compare_writes("load");
    endtask

    task automatic do_dump();
        int          got;
        int          cyc;
        int          stall_err;
        int          user_err;
        logic        stalled;
        logic [7:0]  held;
        logic [7:0]  bytes [8];
        got = 0; cyc = 0; stall_err = 0; user_err = 0; stalled = 1'b0; held = 8'h00;
        send(8'h5A);
        check_eq("dump_rf_user_on", rf_user, 1'b1);
        check_eq("dump_no_core_srst", core_srst, 1'b0);
        while (got < 8 && cyc < 2000) begin
            out_ready = ($urandom_range(0, 3) == 0);
            if (stalled && (!out_valid || out_data !== held)) stall_err++;
            if (out_valid && !rf_user) user_err++;
            if (out_valid && out_ready) begin
                bytes[got] = out_data;
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_eq("dump_count", got, 8);
        for (int i = 0; i < got; i++) check_eq("dump_byte", bytes[i], rf[i]);
        check_eq("dump_stall_stable", stall_err, 0);
        check_eq("dump_rf_user_held", user_err, 0);
        check_eq("dump_end_out_valid", out_valid, 1'b0);
        check_eq("dump_end_rf_user", rf_user, 1'b0);
        check_eq("dump_end_busy", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        srst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_core_srst", core_srst, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_im_wren", im_wren, 1'b0);
        check_eq("rst_rf_user", rf_user, 1'b0);
        check_eq("rst_im_addr", im_addr, 8'h00);
        srst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready_after", in_ready, 1'b1);

        ld_w = '{16'h1234, 16'h5678, 16'h9ABC};
        do_load(8'd3);
        bp = 1;
        do_load(8'd3);

        ld_w.delete();
        for (int i = 0; i < 256; i++) ld_w.push_back(16'($urandom));
        do_load(8'd0);

        for (int i = 0; i < 8; i++) rf[i] = 8'(8'h10 + i);
        do_dump();
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        do_dump();

        got_wr.delete();
        send(8'h3C);
        check_eq("bad_cmd_err", err, 1'b1);
        check_eq("bad_cmd_in_ready", in_ready, 1'b1);
        check_eq("bad_cmd_busy", busy, 1'b0);
        check_eq("bad_cmd_no_wren", got_wr.size(), 0);
        ld_w.delete();
        for (int i = 0; i < 4; i++) ld_w.push_back(16'($urandom));
        do_load(8'd4);
        check_eq("bad_cmd_err_sticky", err, 1'b1);

        ld_w.delete();
        for (int i = 0; i < 5; i++) ld_w.push_back(16'($urandom));
        got_wr.delete();
        exp_wr.delete();
        for (int i = 0; i < 2; i++) exp_wr.push_back({8'(i), ld_w[i]});
        send(8'hA5);
        send(8'd5);
        for (int i = 0; i < 2; i++) begin
            send(ld_w[i][7:0]);
            send(ld_w[i][15:8]);
        end
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check_eq("abort_core_srst", core_srst, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_im_wren", im_wren, 1'b0);
        check_eq("abort_err_cleared", err, 1'b0);
        repeat (5) @(negedge clk);
        compare_writes("abort");
        do_load(8'd5);

        send(8'h5A);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_abort_dump_valid", out_valid, 1'b1);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check_eq("dump_abort_out_valid", out_valid, 1'b0);
        check_eq("dump_abort_rf_user", rf_user, 1'b0);
        check_eq("dump_abort_busy", busy, 1'b0);
        @(negedge clk);
        do_dump();

        repeat (4) begin
            n = $urandom_range(1, 12);
            ld_w.delete();
            for (int i = 0; i < n; i++) ld_w.push_back(16'($urandom));
            do_load(8'(n));
        end

        check_eq("core_srst_during_writes", srst_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
